// File: rtl/cache_assoc.sv
// W-way set-associative write-through cache with byte-masked hart access.
// Misses fill a whole line in order; writes go straight to memory and update the cached word.
//
// state | meaning
// IDLE  | accept requests, serve read hits combinationally, handle invalidate
// FILL  | stream D line reads to memory and load responses into the victim way
// WRITE | present merged write to memory, update cached word when accepted
module cache_assoc #(
    parameter int O = 4,
    parameter int S = 5,
    parameter int W = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid,
    output logic        o_busy,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_ren,
    input  logic        i_req_wen,
    input  logic [3:0]  i_req_mask,
    input  logic [31:0] i_req_wdata,
    output logic [31:0] o_res_rdata,
    input  logic        i_inval,
    output logic [31:0] o_hit_cnt,
    output logic [31:0] o_miss_cnt
);
    localparam int D     = (2 ** O) / 4;
    localparam int DEPTH = 2 ** S;
    localparam int T     = 32 - O - S;
    localparam int DB    = (O > 2) ? O - 2 : 1;
    localparam int KB    = DB + 1;
    localparam int SB    = (S > 0) ? S : 1;
    localparam int WB    = (W > 1) ? $clog2(W) : 1;
    localparam logic [KB-1:0] D_K    = KB'(D);
    localparam logic [KB-1:0] D_LAST = KB'(D - 1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    logic [31:0]   data_q  [W][DEPTH][D];
    logic [T-1:0]  tag_q   [W][DEPTH];
    logic [W-1:0]  valid_q [DEPTH];
    logic [WB-1:0] rr_q    [DEPTH];

    state_t        state_q;
    logic          is_write_q;
    logic [WB-1:0] way_q;
    logic [KB-1:0] req_k_q;
    logic [KB-1:0] rsp_k_q;
    logic [31:0]   hit_cnt_q;
    logic [31:0]   miss_cnt_q;

    logic [SB-1:0] req_set;
    logic [T-1:0]  req_tag;
    logic [DB-1:0] req_word;
    logic [31:0]   line_base;
    logic [31:0]   bmask;
    logic          hit;
    logic [WB-1:0] hit_way;
    logic [WB-1:0] victim;
    logic          found;
    logic          accept;
    logic          last_rsp;
    logic [31:0]   hit_word;
    logic [31:0]   line_word;
    logic [31:0]   fill_word;
    logic [31:0]   wr_merge;

    assign req_set   = SB'((i_req_addr >> O) & 32'(DEPTH - 1));
    assign req_tag   = T'(i_req_addr >> (O + S));
    assign req_word  = DB'((i_req_addr >> 2) & 32'(D - 1));
    assign line_base = i_req_addr & ~(32'(2 ** O) - 32'd1);
    assign bmask     = {{8{i_req_mask[3]}}, {8{i_req_mask[2]}},
                        {8{i_req_mask[1]}}, {8{i_req_mask[0]}}};
    assign accept    = (state_q == IDLE) && (i_req_ren || i_req_wen);
    assign last_rsp  = (state_q == FILL) && i_mem_valid && (rsp_k_q == D_LAST);

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < W; w++) begin
            if (valid_q[req_set][w] && (tag_q[w][req_set] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WB'(w);
            end
        end
    end

    always_comb begin
        victim = rr_q[req_set];
        found  = 1'b0;
        for (int w = 0; w < W; w++) begin
            if (!found && !valid_q[req_set][w]) begin
                victim = WB'(w);
                found  = 1'b1;
            end
        end
    end

    assign hit_word  = data_q[hit_way][req_set][req_word];
    assign line_word = data_q[way_q][req_set][req_word];
    // The requested word may be the one arriving on the final response cycle.
    assign fill_word = (rsp_k_q[DB-1:0] == req_word) ? i_mem_rdata : line_word;
    assign wr_merge  = (line_word & ~bmask) | (i_req_wdata & bmask);

    always_comb begin
        o_busy      = 1'b0;
        o_res_rdata = '0;
        o_mem_ren   = 1'b0;
        o_mem_wen   = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (i_req_ren || i_req_wen) begin
                    if (hit && !i_req_wen) o_res_rdata = hit_word & bmask;
                    else                   o_busy      = 1'b1;
                end
            end
            FILL: begin
                o_busy = !(last_rsp && !is_write_q);
                if (last_rsp && !is_write_q) o_res_rdata = fill_word & bmask;
                if (req_k_q < D_K) begin
                    o_mem_ren  = 1'b1;
                    o_mem_addr = line_base + (32'(req_k_q) << 2);
                end
            end
            WRITE: begin
                o_busy      = !i_mem_ready;
                o_mem_wen   = 1'b1;
                o_mem_addr  = i_req_addr;
                o_mem_wdata = wr_merge;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            is_write_q <= 1'b0;
            way_q      <= '0;
            req_k_q    <= '0;
            rsp_k_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
                            if (i_req_wen) begin
                                state_q    <= WRITE;
                                way_q      <= hit_way;
                                is_write_q <= 1'b1;
                            end
                        end else begin
                            if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
                            state_q    <= FILL;
                            way_q      <= victim;
                            is_write_q <= i_req_wen;
                            req_k_q    <= '0;
                            rsp_k_q    <= '0;
                        end
                    end
                    if (i_inval) begin
                        for (int s = 0; s < DEPTH; s++) begin
                            valid_q[s] <= '0;
                            rr_q[s]    <= '0;
                        end
                    end
                end
                FILL: begin
                    if (i_mem_ready && (req_k_q < D_K)) req_k_q <= req_k_q + 1'b1;
                    if (i_mem_valid) begin
                        data_q[way_q][req_set][rsp_k_q[DB-1:0]] <= i_mem_rdata;
                        rsp_k_q <= rsp_k_q + 1'b1;
                        if (rsp_k_q == D_LAST) begin
                            tag_q[way_q][req_set]   <= req_tag;
                            valid_q[req_set][way_q] <= 1'b1;
                            rr_q[req_set]           <= (W == 1) ? '0 : rr_q[req_set] + 1'b1;
                            state_q                 <= is_write_q ? WRITE : IDLE;
                        end
                    end
                end
                WRITE: begin
                    if (i_mem_ready) begin
                        data_q[way_q][req_set][req_word] <= wr_merge;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_hit_cnt  = hit_cnt_q;
    assign o_miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_cache_assoc.sv
// Directed bench for cache_assoc (default O=4, S=5, W=2) with an in-order memory responder.
// Untouched memory words hold 0xC0DE0000 | address.
module tb_cache_assoc;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_mem_ready;
    logic [31:0] o_mem_addr;
    logic        o_mem_ren;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        i_mem_valid;
    logic        o_busy;
    logic [31:0] i_req_addr;
    logic        i_req_ren;
    logic        i_req_wen;
    logic [3:0]  i_req_mask;
    logic [31:0] i_req_wdata;
    logic [31:0] o_res_rdata;
    logic        i_inval;
    logic [31:0] o_hit_cnt;
    logic [31:0] o_miss_cnt;

    cache_assoc dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr),
        .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
        .i_mem_valid(i_mem_valid), .o_busy(o_busy),
        .i_req_addr(i_req_addr), .i_req_ren(i_req_ren),
        .i_req_wen(i_req_wen), .i_req_mask(i_req_mask),
        .i_req_wdata(i_req_wdata), .o_res_rdata(o_res_rdata),
        .i_inval(i_inval), .o_hit_cnt(o_hit_cnt), .o_miss_cnt(o_miss_cnt)
    );

    always #5 i_clk = ~i_clk;

    logic [31:0] mem_m [0:1023];
    logic [31:0] pend [$];
    logic [31:0] seen_rd [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rsp_cnt = 0;
    int          n_wen = 0;
    int          excl_viol = 0;
    logic        toggle_ready = 1'b0;
    logic        cap_busy;
    logic [31:0] cap_rdata;
    logic [31:0] last_waddr;
    logic [31:0] last_wdata;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock: drive memory side at the falling edge, sample just after, then advance.
    task automatic tick();
        logic [31:0] a;
        i_mem_ready = toggle_ready ? ((cyc % 2) == 0) : 1'b1;
        if (pend.size() > 0) begin
            a           = pend.pop_front();
            i_mem_valid = 1'b1;
            i_mem_rdata = mem_m[a[11:2]];
            rsp_cnt++;
        end else begin
            i_mem_valid = 1'b0;
            i_mem_rdata = '0;
        end
        #1;
        cap_busy  = o_busy;
        cap_rdata = o_res_rdata;
        if (o_mem_ren && o_mem_wen) excl_viol++;
        if (!o_mem_ren && !o_mem_wen && (o_mem_addr != 0 || o_mem_wdata != 0)) excl_viol++;
        if (o_mem_ren && i_mem_ready) begin
            pend.push_back(o_mem_addr);
            seen_rd.push_back(o_mem_addr);
        end
        if (o_mem_wen && i_mem_ready) begin
            n_wen++;
            last_waddr = o_mem_addr;
            last_wdata = o_mem_wdata;
            a = o_mem_addr;
            mem_m[a[11:2]] = o_mem_wdata;
        end
        @(posedge i_clk);
        @(negedge i_clk);
        cyc++;
    endtask

    task automatic access(input logic wr, input logic [31:0] a, input logic [3:0] m,
                          input logic [31:0] wd, input logic inv,
                          output logic [31:0] rd, output int n);
        i_req_addr  = a;
        i_req_mask  = m;
        i_req_wdata = wd;
        i_req_ren   = !wr;
        i_req_wen   = wr;
        i_inval     = inv;
        n = 0;
        do begin
            tick();
            n++;
            i_req_ren = 1'b0;
            i_req_wen = 1'b0;
            i_inval   = 1'b0;
        end while (cap_busy && n < 200);
        chk("done", 32'(cap_busy), 32'd0);
        rd = cap_rdata;
    endtask

    logic [31:0] rd;
    int          n;
    int          rsp0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem_m[i] = 32'hC0DE_0000 | 32'(i * 4);
        mem_m[32'h300 >> 2] = 32'h1122_3344;
        i_rst = 1'b1; i_inval = 1'b0; i_req_ren = 1'b0; i_req_wen = 1'b0;
        i_req_addr = '0; i_req_mask = '0; i_req_wdata = '0;
        i_mem_ready = 1'b1; i_mem_valid = 1'b0; i_mem_rdata = '0;
        @(negedge i_clk);
        repeat (3) tick();
        i_rst = 1'b0;
        #1;
        chk("rst_busy",  32'(o_busy), 32'd0);
        chk("rst_ren",   32'(o_mem_ren), 32'd0);
        chk("rst_wen",   32'(o_mem_wen), 32'd0);
        chk("rst_addr",  o_mem_addr, 32'd0);
        chk("rst_wdata", o_mem_wdata, 32'd0);
        chk("rst_rdata", o_res_rdata, 32'd0);
        chk("rst_hit",   o_hit_cnt, 32'd0);
        chk("rst_miss",  o_miss_cnt, 32'd0);
        @(negedge i_clk);

        // cold read then repeat hit
        seen_rd.delete();
        rsp0 = rsp_cnt;
        access(1'b0, 32'h104, 4'hF, '0, 1'b0, rd, n);
        chk("cold_rdata", rd, 32'hC0DE_0104);
        chk("cold_lat", 32'(n), 32'd6);
        chk("cold_rsps", 32'(rsp_cnt - rsp0), 32'd4);
        chk("cold_nrd", 32'(seen_rd.size()), 32'd4);
        for (int k = 0; k < 4; k++) chk("cold_addr", seen_rd[k], 32'h100 + 32'(4 * k));
        access(1'b0, 32'h104, 4'hF, '0, 1'b0, rd, n);
        chk("hit_rdata", rd, 32'hC0DE_0104);
        chk("hit_lat", 32'(n), 32'd1);
        chk("hit_cnt1", o_hit_cnt, 32'd1);
        chk("miss_cnt1", o_miss_cnt, 32'd1);

        // byte-masked write hits and masked read
        access(1'b0, 32'h300, 4'hF, '0, 1'b0, rd, n);
        chk("r300", rd, 32'h1122_3344);
        access(1'b1, 32'h300, 4'b0100, 32'hAABB_CCDD, 1'b0, rd, n);
        chk("w300_n", 32'(n_wen), 32'd1);
        chk("w300_addr", last_waddr, 32'h300);
        chk("w300_data", last_wdata, 32'h11BB_3344);
        access(1'b0, 32'h300, 4'hF, '0, 1'b0, rd, n);
        chk("r300_after", rd, 32'h11BB_3344);
        chk("r300_lat", 32'(n), 32'd1);
        access(1'b1, 32'h304, 4'b0101, 32'hAABB_CCDD, 1'b0, rd, n);
        chk("w304_data", last_wdata, 32'hC0BB_03DD);
        access(1'b0, 32'h304, 4'b0011, '0, 1'b0, rd, n);
        chk("r304_mask", rd, 32'h0000_03DD);
        chk("hit_cnt2", o_hit_cnt, 32'd5);
        chk("miss_cnt2", o_miss_cnt, 32'd2);

        // replacement in set 0: A=0x000 B=0x200 C=0x400 D=0x600
        access(1'b0, 32'h000, 4'hF, '0, 1'b0, rd, n);
        access(1'b0, 32'h200, 4'hF, '0, 1'b0, rd, n);
        access(1'b0, 32'h400, 4'hF, '0, 1'b0, rd, n);
        access(1'b0, 32'h600, 4'hF, '0, 1'b0, rd, n);
        chk("rD_data", rd, 32'hC0DE_0600);
        access(1'b0, 32'h400, 4'hF, '0, 1'b0, rd, n);
        chk("C_hit", 32'(n), 32'd1);
        access(1'b0, 32'h600, 4'hF, '0, 1'b0, rd, n);
        chk("D_hit", 32'(n), 32'd1);
        access(1'b0, 32'h000, 4'hF, '0, 1'b0, rd, n);
        chk("A_miss", 32'(n > 1), 32'd1);
        access(1'b0, 32'h600, 4'hF, '0, 1'b0, rd, n);
        chk("D_hit2", 32'(n), 32'd1);
        access(1'b0, 32'h400, 4'hF, '0, 1'b0, rd, n);
        chk("C_miss", 32'(n > 1), 32'd1);
        chk("hit_cnt3", o_hit_cnt, 32'd8);
        chk("miss_cnt3", o_miss_cnt, 32'd8);

        // ready toggling during fill; requested word is the last to arrive
        toggle_ready = 1'b1;
        seen_rd.delete();
        access(1'b0, 32'h84C, 4'hF, '0, 1'b0, rd, n);
        toggle_ready = 1'b0;
        chk("tog_rdata", rd, 32'hC0DE_084C);
        chk("tog_nrd", 32'(seen_rd.size()), 32'd4);
        for (int k = 0; k < 4; k++) chk("tog_addr", seen_rd[k], 32'h840 + 32'(4 * k));

        // reset after the second fill response
        rsp0 = rsp_cnt;
        n = 0;
        i_req_addr = 32'h880; i_req_mask = 4'hF; i_req_ren = 1'b1;
        tick();
        i_req_ren = 1'b0;
        while ((rsp_cnt - rsp0) < 2 && n < 50) begin
            tick();
            n++;
        end
        chk("abort_rsps", 32'(rsp_cnt - rsp0), 32'd2);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        repeat (8) tick();
        chk("abort_busy", 32'(cap_busy), 32'd0);
        chk("abort_hit", o_hit_cnt, 32'd0);
        chk("abort_miss", o_miss_cnt, 32'd0);
        access(1'b0, 32'h880, 4'hF, '0, 1'b0, rd, n);
        chk("abort_refill", 32'(n > 1), 32'd1);
        chk("abort_rdata", rd, 32'hC0DE_0880);
        chk("abort_miss2", o_miss_cnt, 32'd1);

        // invalidate
        access(1'b0, 32'h880, 4'hF, '0, 1'b0, rd, n);
        chk("inv_warm", 32'(n), 32'd1);
        i_inval = 1'b1;
        tick();
        i_inval = 1'b0;
        access(1'b0, 32'h888, 4'hF, '0, 1'b0, rd, n);
        chk("inv_miss", 32'(n > 1), 32'd1);
        chk("inv_rdata", rd, 32'hC0DE_0888);
        access(1'b0, 32'h884, 4'hF, '0, 1'b1, rd, n);
        chk("inv_same_hit", 32'(n), 32'd1);
        chk("inv_same_data", rd, 32'hC0DE_0884);
        access(1'b0, 32'h880, 4'hF, '0, 1'b0, rd, n);
        chk("inv_after", 32'(n > 1), 32'd1);
        chk("inv_miss_cnt", o_miss_cnt, 32'd3);
        chk("inv_hit_cnt", o_hit_cnt, 32'd2);

        // write miss: fill, then one merged memory write
        access(1'b1, 32'hC00, 4'b1001, 32'hDEAD_BEEF, 1'b0, rd, n);
        chk("wm_n", 32'(n_wen), 32'd3);
        chk("wm_addr", last_waddr, 32'hC00);
        chk("wm_data", last_wdata, 32'hDEDE_0CEF);
        access(1'b0, 32'hC00, 4'hF, '0, 1'b0, rd, n);
        chk("wm_read", rd, 32'hDEDE_0CEF);
        chk("wm_read_lat", 32'(n), 32'd1);
        chk("final_hit", o_hit_cnt, 32'd3);
        chk("final_miss", o_miss_cnt, 32'd4);
        chk("mem_excl", 32'(excl_viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
